// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache sequencing controller.
// Address layout is tag[15:11], index[10:3], offset[2:0].
package cache_ctrl_pkg;
    localparam int TAG_W  = 5;
    localparam int IDX_W  = 8;
    localparam int OFF_W  = 3;
    localparam int WORDS  = 4;
    localparam int ADDR_W = TAG_W + IDX_W + OFF_W;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, WB2, WB3, RD0, RD1, RD2, RD3, FILL, LAST
    } state_t;

    // Word k of a line sits at byte offset 2k.
    function automatic logic [OFF_W-1:0] beat_off(input logic [1:0] beat);
        return {beat, 1'b0};
    endfunction
endpackage

// File: rtl/cache_ctrl_if.sv
// Processor, cache-status/control and memory-request signals of cache_ctrl.
// master = the controller, slave = the surrounding datapath/requester.
interface cache_ctrl_if;
    import cache_ctrl_pkg::*;

    logic [ADDR_W-1:0] Addr;
    logic              Rd;
    logic              Wr;
    logic              Done;
    logic              Stall;
    logic              CacheHit;
    logic              err;

    logic              c_enable;
    logic              c_comp;
    logic              c_write;
    logic              c_valid_in;
    logic [OFF_W-1:0]  c_offset;
    logic              c_din_sel;
    logic              c_hit;
    logic              c_dirty;
    logic              c_valid;
    logic              c_err;
    logic [TAG_W-1:0]  c_tag_out;

    logic [ADDR_W-1:0] m_addr;
    logic              m_rd;
    logic              m_wr;
    logic              m_stall;
    logic              m_err;

    modport master (
        input  Addr, Rd, Wr, c_hit, c_dirty, c_valid, c_err, c_tag_out, m_stall, m_err,
        output Done, Stall, CacheHit, err, c_enable, c_comp, c_write, c_valid_in,
               c_offset, c_din_sel, m_addr, m_rd, m_wr
    );

    modport slave (
        output Addr, Rd, Wr, c_hit, c_dirty, c_valid, c_err, c_tag_out, m_stall, m_err,
        input  Done, Stall, CacheHit, err, c_enable, c_comp, c_write, c_valid_in,
               c_offset, c_din_sel, m_addr, m_rd, m_wr
    );
endinterface

// File: rtl/fill_tracker.sv
// Delays each accepted memory read offset by MEM_LAT cycles so the matching
// cache fill write lines up with returning data, and counts words written.
module fill_tracker
    import cache_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [OFF_W-1:0] push_off,
    output logic             fill_we,
    output logic [OFF_W-1:0] fill_off,
    output logic             fill_last,
    output logic             fill_done
);
    logic [MEM_LAT-1:0] vld_p;
    logic [OFF_W-1:0]   off_p [MEM_LAT];
    logic [2:0]         cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            cnt   <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                off_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= push;
            off_p[0] <= push_off;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                off_p[i] <= off_p[i-1];
            end
            if (clr) begin
                cnt <= '0;
            end else if (fill_we) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    assign fill_we   = vld_p[MEM_LAT-1];
    assign fill_off  = off_p[MEM_LAT-1];
    assign fill_last = fill_we && (cnt == 3'(WORDS - 1));
    assign fill_done = (cnt == 3'(WORDS));
endmodule

// File: rtl/cache_ctrl.sv
// Sequencing FSM for a direct-mapped write-back cache over banked memory:
// compare, write back dirty victim, fill line, replay the access.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input logic          clk,
    input logic          rst,
    cache_ctrl_if.master bus
);
    state_t            state, state_nxt;
    logic              quiet_q, quiet;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [TAG_W-1:0]  vtag_q;
    logic              lat_en;
    logic              illegal;
    logic [1:0]        beat;

    logic              done, stall, cache_hit, err;
    logic              c_en, c_cmp, c_wr, c_vin, c_dsel;
    logic [OFF_W-1:0]  c_off;
    logic              m_rd, m_wr;
    logic [ADDR_W-1:0] m_addr;

    logic              fill_we, fill_last, fill_done;
    logic [OFF_W-1:0]  fill_off;

    // Outputs stay silent during reset and for one cycle after it.
    assign quiet = rst | quiet_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            quiet_q <= 1'b1;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            vtag_q  <= '0;
        end else begin
            state   <= state_nxt;
            quiet_q <= 1'b0;
            if (lat_en) begin
                addr_q <= bus.Addr;
                wr_q   <= bus.Wr;
                vtag_q <= bus.c_tag_out;
            end
        end
    end

    always_comb begin
        case (state)
            WB1, RD1: beat = 2'd1;
            WB2, RD2: beat = 2'd2;
            WB3, RD3: beat = 2'd3;
            default:  beat = 2'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        lat_en    = 1'b0;
        illegal   = 1'b0;
        done      = 1'b0;
        stall     = 1'b0;
        cache_hit = 1'b0;
        err       = 1'b0;
        c_en      = 1'b0;
        c_cmp     = 1'b0;
        c_wr      = 1'b0;
        c_vin     = 1'b0;
        c_dsel    = 1'b0;
        c_off     = '0;
        m_rd      = 1'b0;
        m_wr      = 1'b0;
        m_addr    = '0;
        if (quiet) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Rd | bus.Wr) begin
                        if ((bus.Rd & bus.Wr) | bus.Addr[0]) begin
                            illegal = 1'b1;
                            done    = 1'b1;
                        end else begin
                            c_en   = 1'b1;
                            c_cmp  = 1'b1;
                            c_wr   = bus.Wr;
                            c_off  = bus.Addr[OFF_W-1:0];
                            lat_en = 1'b1;
                            if (bus.c_hit & bus.c_valid) begin
                                done      = 1'b1;
                                cache_hit = 1'b1;
                            end else if (bus.c_valid & bus.c_dirty) begin
                                state_nxt = WB0;
                            end else begin
                                state_nxt = RD0;
                            end
                        end
                    end
                end
                WB0, WB1, WB2, WB3: begin
                    c_en   = 1'b1;
                    c_off  = beat_off(beat);
                    m_wr   = 1'b1;
                    m_addr = {vtag_q, addr_q[IDX_W+OFF_W-1:OFF_W], beat_off(beat)};
                    if (!bus.m_stall) begin
                        state_nxt = (state == WB3) ? RD0 : state_t'(state + 4'd1);
                    end
                end
                RD0, RD1, RD2, RD3: begin
                    m_rd   = 1'b1;
                    m_addr = {addr_q[ADDR_W-1:OFF_W], beat_off(beat)};
                    if (!bus.m_stall) begin
                        state_nxt = (state == RD3) ? FILL : state_t'(state + 4'd1);
                    end
                end
                FILL: begin
                    if (fill_last | fill_done) begin
                        state_nxt = LAST;
                    end
                end
                LAST: begin
                    c_en      = 1'b1;
                    c_cmp     = 1'b1;
                    c_wr      = wr_q;
                    c_off     = addr_q[OFF_W-1:0];
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase

            // Returning fill data owns the cache port; only RDk/FILL overlap it.
            if (fill_we) begin
                c_en   = 1'b1;
                c_cmp  = 1'b0;
                c_wr   = 1'b1;
                c_dsel = 1'b1;
                c_off  = fill_off;
                c_vin  = fill_last;
            end
            stall = (state != IDLE);
            err   = illegal | bus.c_err | bus.m_err;
        end
    end

    fill_tracker #(
        .MEM_LAT (MEM_LAT)
    ) u_fill (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == LAST),
        .push      (m_rd & ~bus.m_stall),
        .push_off  (m_addr[OFF_W-1:0]),
        .fill_we   (fill_we),
        .fill_off  (fill_off),
        .fill_last (fill_last),
        .fill_done (fill_done)
    );

    assign bus.Done       = done;
    assign bus.Stall      = stall;
    assign bus.CacheHit   = cache_hit;
    assign bus.err        = err;
    assign bus.c_enable   = c_en;
    assign bus.c_comp     = c_cmp;
    assign bus.c_write    = c_wr;
    assign bus.c_valid_in = c_vin;
    assign bus.c_offset   = c_off;
    assign bus.c_din_sel  = c_dsel;
    assign bus.m_addr     = m_addr;
    assign bus.m_rd       = m_rd;
    assign bus.m_wr       = m_wr;
endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for the direct-mapped, write-back cache and the four-bank main memory inside `mem_system`. It accepts one processor Rd/Wr request at a time and compares it against the cache. On a miss it writes back a dirty victim line, fills the line from memory, and replays the access. It drives only control, offset and address signals; the cache's and memory's data buses stay in the datapath, and the controller selects the cache write-data source.

## Interface
- `MEM_LAT`, default 2: cycles from an accepted memory read (`m_rd & ~m_stall`) to valid read data.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `Addr` in 16: request byte address; tag [15:11], index [10:3], offset [2:0].
- `Rd`, `Wr` in 1: request strobes, sampled in IDLE.
- `Done` out 1: one-cycle pulse, request complete; cache `data_out` is valid this cycle for reads.
- `Stall` out 1: controller busy (state ≠ IDLE).
- `CacheHit` out 1: with `Done`, request hit on first compare.
- `err` out 1: illegal request, or `c_err`/`m_err`.
- `c_enable`, `c_comp`, `c_write`, `c_valid_in` out 1: cache controls.
- `c_offset` out 3: cache word offset.
- `c_din_sel` out 1: cache write data source; 0 = latched DataIn, 1 = memory read data.
- `c_hit`, `c_dirty`, `c_valid`, `c_err` in 1: cache status.
- `c_tag_out` in 5: tag of the indexed line.
- `m_addr` out 16, `m_rd` out 1, `m_wr` out 1: memory request; memory write data is cache `data_out`.
- `m_stall`, `m_err` in 1: memory busy/stall, memory error.

## Operation
- Line = 4 words at offsets 0,2,4,6. `Addr[0]=1` is misaligned.
- **IDLE**
  - `Rd&Wr`, or `(Rd|Wr)&Addr[0]`: `err=1`, `Done=1`, no cache or memory access, stay in IDLE.
  - Legal request: `c_enable=1`, `c_comp=1`, `c_write=Wr`, `c_offset=Addr[2:0]`, `c_din_sel=0`.
  - On the request cycle, latch `Addr`, `Wr`, and `c_tag_out` (victim tag). The datapath latches `DataIn` in the same cycle.
  - `c_hit&c_valid`: `Done=1`, `CacheHit=1`, stay in IDLE.
  - Otherwise go to WB0 if `c_valid&c_dirty`, else to RD0.
- **WBk** (k=0..3)
  - `c_enable=1`, `c_comp=0`, `c_write=0`, `c_offset=2k`.
  - `m_wr=1`, `m_addr={victim_tag, index, 2k}`.
  - `m_stall`: hold the state and all outputs.
  - WB3 not stalled → RD0.
- **RDk** (k=0..3)
  - `m_rd=1`, `m_addr={tag, index, 2k}`.
  - `m_stall`: hold the state and all outputs.
  - RD3 not stalled → FILL.
- **Fill tracking (RDk and FILL)**
  - Each accepted read pushes its offset into a `MEM_LAT`-deep pipe.
  - When an offset emerges: `c_enable=1`, `c_comp=0`, `c_write=1`, `c_din_sel=1`, `c_offset=popped`.
  - `c_valid_in=1` only for the 4th word written; earlier fill writes use `c_valid_in=0`, so a partial line stays invalid.
  - A 3-bit fill counter counts written words.
- **FILL**: wait until the fill counter reaches 4, then go to LAST.
- **LAST**
  - Replay the access: `c_enable=1`, `c_comp=1`, `c_write=latched Wr`, `c_din_sel=0`, `c_offset=latched offset`.
  - `Done=1`, `CacheHit=0`, then IDLE.
- `err` also equals `c_err|m_err` in any state; it does not alter sequencing.
- Requests arriving while Stall=1 are ignored. The requester holds them until `Done`.

## Timing
- Reset:
  - state=IDLE; fill pipe, fill counter and latches cleared.
  - All outputs 0 while `rst=1` and on the first cycle after reset.
  - Reset mid-transaction abandons it; a partially filled line is left invalid.
- Hit latency 0: `Done` in the request cycle.
- Clean miss, no stalls: `Done` 7 cycles after the request cycle (RD0..RD3 at +1..+4, fill writes at +3..+6, LAST at +7).
- Dirty miss, no stalls: `Done` at +11.
- Each `m_stall` cycle adds exactly one cycle.
- `Done` never asserts in two consecutive cycles of one request.

## Structure
- Package `cache_ctrl_pkg` holds:
  - State enum: IDLE, WB0-3, RD0-3, FILL, LAST.
  - Constants TAG_W=5, IDX_W=8, OFF_W=3, WORDS=4.
- Sub-module `fill_tracker`:
  - `MEM_LAT`-deep valid+offset shift pipe plus the fill counter.
  - Outputs `fill_we`, `fill_off`, `fill_last`, `fill_done`.
- `cache_ctrl` holds the FSM and output decode.

## Test plan
- **Clean read miss**: after reset, Rd to 0x0808.
  - `m_rd` on addresses 0x0808, 0x080A, 0x080C, 0x080E in cycles +1..+4.
  - Fill writes at +3..+6; `c_valid_in` only at +6.
  - `Done=1`, `CacheHit=0` at +7.
- **Read hit**: repeat Rd 0x0808 → `Done=1`, `CacheHit=1`, `Stall=0` the same cycle; no memory access.
- **Dirty miss**: Wr 0x0808 (hit, makes the line dirty), then Rd 0x8808.
  - `m_wr` on 0x0808..0x080E at +1..+4.
  - `m_rd` on 0x8808..0x880E at +5..+8.
  - `Done` at +11.
- **Memory stall**: `m_stall=1` for 3 cycles while in RD1 → `m_addr` held at 0x080A; `Done` at +10.
- **Illegal requests**: `Rd=Wr=1`, or Rd with `Addr=0x0809` → `err=1` and `Done=1` the same cycle; `c_enable=m_rd=m_wr=0`.
- **Reset mid-fill**: assert `rst` during RD2 of a miss to 0x0808.
  - Next cycle: IDLE, all outputs 0.
  - A subsequent Rd 0x0808 misses and refills.
